// File: rtl/port_arbiter_pkg.sv
// Shared constants and types for the I/O port bus arbiter.
// State encodings are fixed 2-bit values so other blocks can decode the arbiter state.
package port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // Wait counter must hold WAIT_CYCLES-1 for the largest allowed window (15).
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping modulo NUM_REQ.
// Purely combinational; the pointer is owned by the arbiter FSM.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   sum_w  [NUM_REQ];
  logic [IDX_W:0]   wrap_w [NUM_REQ];
  logic [IDX_W-1:0] cand_w [NUM_REQ];
  logic [NUM_REQ-1:0] hit_w;

  // Candidate gi is the requester gi slots after the pointer; explicit wrap covers non-power-of-2 counts.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign sum_w[gi]  = {1'b0, ptr_i} + (IDX_W+1)'(gi);
    assign wrap_w[gi] = sum_w[gi] - NREQ_W;
    assign cand_w[gi] = (sum_w[gi] >= NREQ_W) ? wrap_w[gi][IDX_W-1:0] : sum_w[gi][IDX_W-1:0];
    assign hit_w[gi]  = req_i[cand_w[gi]];
  end

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit_w[i]) begin
        valid_o = 1'b1;
        idx_o   = cand_w[i];
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Shares the single I/O port bus between NUM_REQ requesters with round-robin arbitration,
// one transaction in flight, a WAIT_CYCLES access window and a one-cycle ack pulse.
module port_arbiter
  import port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_REQ     = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         do_reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           wr,
  input  logic [NUM_REQ*WORD_SIZE-1:0] addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0] wdata,
  output logic [NUM_REQ-1:0]           ack,
  output logic [WORD_SIZE-1:0]         rdata,
  output logic                         busy,
  output logic [WORD_SIZE-1:0]         portaddr,
  output logic [WORD_SIZE-1:0]         portval,
  output logic                         portget,
  output logic                         portset,
  input  logic [WORD_SIZE-1:0]         portout
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic                   wr_q, wr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
  logic [WORD_SIZE-1:0]   portaddr_q, portaddr_d;
  logic [WORD_SIZE-1:0]   portval_q, portval_d;
  logic                   portget_q, portget_d;
  logic                   portset_q, portset_d;

  logic [WORD_SIZE-1:0]   addr_arr  [NUM_REQ];
  logic [WORD_SIZE-1:0]   wdata_arr [NUM_REQ];
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[gi*WORD_SIZE +: WORD_SIZE];
    assign wdata_arr[gi] = wdata[gi*WORD_SIZE +: WORD_SIZE];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (do_reset) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      portaddr_q <= '0;
      portval_q  <= '0;
      portget_q  <= 1'b0;
      portset_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      portaddr_q <= portaddr_d;
      portval_q  <= portval_d;
      portget_q  <= portget_d;
      portset_q  <= portset_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    portaddr_d = portaddr_q;
    portval_d  = portval_q;
    portget_d  = 1'b0;
    portset_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          win_d      = pick_idx;
          wr_d       = wr[pick_idx];
          portaddr_d = addr_arr[pick_idx];
          portval_d  = wdata_arr[pick_idx];
          cnt_d      = CNT_INIT;
          // Strobes are registered, so they are set up here to appear in the first ACCESS cycle.
          portset_d  = wr[pick_idx];
          portget_d  = ~wr[pick_idx];
          state_d    = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            rdata_d = portout;
          end
          ack_d[win_q] = 1'b1;
          state_d      = ARB_DONE;
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          portget_d = ~wr_q;
        end
      end
      ARB_DONE: begin
        ptr_d   = (win_q == IDX_LAST) ? '0 : win_q + IDX_ONE;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != ARB_IDLE);
  assign portaddr = portaddr_q;
  assign portval  = portval_q;
  assign portget  = portget_q;
  assign portset  = portset_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: a cycle table for a 2-requester/1-wait instance, plus
// hand sequences for a 3-wait instance (read, reset abort) and a 3-requester instance (wrap).
module tb_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: NUM_REQ=2, WAIT_CYCLES=1
  logic        a_rst = 1'b1;
  logic [1:0]  a_req = '0, a_wr = '0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [15:0] a_pout = '0;
  logic [1:0]  a_ack;
  logic [15:0] a_rdata, a_paddr, a_pval;
  logic        a_busy, a_get, a_set;

  port_arbiter #(.WORD_SIZE(16), .NUM_REQ(2), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .do_reset(a_rst), .req(a_req), .wr(a_wr), .addr(a_addr), .wdata(a_wdata),
    .ack(a_ack), .rdata(a_rdata), .busy(a_busy), .portaddr(a_paddr), .portval(a_pval),
    .portget(a_get), .portset(a_set), .portout(a_pout)
  );

  // Instance B: NUM_REQ=2, WAIT_CYCLES=3
  logic        b_rst = 1'b1;
  logic [1:0]  b_req = '0, b_wr = '0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [15:0] b_pout = '0;
  logic [1:0]  b_ack;
  logic [15:0] b_rdata, b_paddr, b_pval;
  logic        b_busy, b_get, b_set;

  port_arbiter #(.WORD_SIZE(16), .NUM_REQ(2), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .do_reset(b_rst), .req(b_req), .wr(b_wr), .addr(b_addr), .wdata(b_wdata),
    .ack(b_ack), .rdata(b_rdata), .busy(b_busy), .portaddr(b_paddr), .portval(b_pval),
    .portget(b_get), .portset(b_set), .portout(b_pout)
  );

  // Instance C: NUM_REQ=3, WAIT_CYCLES=1
  logic        c_rst = 1'b1;
  logic [2:0]  c_req = '0, c_wr = '0;
  logic [47:0] c_addr = {16'h0C02, 16'h0C01, 16'h0C00};
  logic [47:0] c_wdata = '0;
  logic [15:0] c_pout = '0;
  logic [2:0]  c_ack;
  logic [15:0] c_rdata, c_paddr, c_pval;
  logic        c_busy, c_get, c_set;

  port_arbiter #(.WORD_SIZE(16), .NUM_REQ(3), .WAIT_CYCLES(1)) u_dut_c (
    .clk(clk), .do_reset(c_rst), .req(c_req), .wr(c_wr), .addr(c_addr), .wdata(c_wdata),
    .ack(c_ack), .rdata(c_rdata), .busy(c_busy), .portaddr(c_paddr), .portval(c_pval),
    .portget(c_get), .portset(c_set), .portout(c_pout)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req, wr;
    logic [15:0] a0, d0, a1, d1, pout;
    logic [1:0]  e_ack;
    logic        e_busy, e_set, e_get;
    logic [15:0] e_paddr, e_pval, e_rdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic rst, input logic [1:0] req, input logic [1:0] wr,
    input logic [15:0] a0, input logic [15:0] d0, input logic [15:0] a1, input logic [15:0] d1,
    input logic [15:0] pout, input logic [1:0] e_ack, input logic e_busy, input logic e_set,
    input logic e_get, input logic [15:0] e_paddr, input logic [15:0] e_pval,
    input logic [15:0] e_rdata);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.pout = pout; v.e_ack = e_ack; v.e_busy = e_busy; v.e_set = e_set; v.e_get = e_get;
    v.e_paddr = e_paddr; v.e_pval = e_pval; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pa, pout_t, prev_rd;
    logic [1:0]  ack_e;

    // ---- Table for instance A ----
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 2'b01, 2'b01, 16'h0010, 16'hBEEF, 0, 0, 0, 2'b00, 1, 1, 0, 16'h0010, 16'hBEEF, 0));
    vt.push_back(mk(0, 2'b01, 2'b01, 16'h0010, 16'hBEEF, 0, 0, 0, 2'b01, 1, 0, 0, 16'h0010, 16'hBEEF, 0));
    vt.push_back(mk(0, 2'b01, 2'b01, 16'h0010, 16'hBEEF, 0, 0, 0, 2'b00, 0, 0, 0, 16'h0010, 16'hBEEF, 0));
    vt.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 16'h0010, 16'hBEEF, 0));
    vt.push_back(mk(1, 2'b11, 2'b00, 16'h0100, 0, 16'h0200, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int t = 0; t < 6; t++) begin
      pa      = t[0] ? 16'h0200 : 16'h0100;
      ack_e   = t[0] ? 2'b10 : 2'b01;
      pout_t  = 16'h1000 + 16'(t);
      prev_rd = (t == 0) ? 16'h0000 : 16'h1000 + 16'(t - 1);
      vt.push_back(mk(0, 2'b11, 2'b00, 16'h0100, 0, 16'h0200, 0, pout_t, 2'b00, 1, 0, 1, pa, 0, prev_rd));
      vt.push_back(mk(0, 2'b11, 2'b00, 16'h0100, 0, 16'h0200, 0, pout_t, ack_e, 1, 0, 0, pa, 0, pout_t));
      vt.push_back(mk(0, 2'b11, 2'b00, 16'h0100, 0, 16'h0200, 0, pout_t, 2'b00, 0, 0, 0, pa, 0, pout_t));
    end

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      a_rst   = vt[i].rst;
      a_req   = vt[i].req;
      a_wr    = vt[i].wr;
      a_addr  = {vt[i].a1, vt[i].a0};
      a_wdata = {vt[i].d1, vt[i].d0};
      a_pout  = vt[i].pout;
      tick();
      chk($sformatf("A row%0d ack", i),      48'(a_ack),   48'(vt[i].e_ack));
      chk($sformatf("A row%0d busy", i),     48'(a_busy),  48'(vt[i].e_busy));
      chk($sformatf("A row%0d portset", i),  48'(a_set),   48'(vt[i].e_set));
      chk($sformatf("A row%0d portget", i),  48'(a_get),   48'(vt[i].e_get));
      chk($sformatf("A row%0d portaddr", i), 48'(a_paddr), 48'(vt[i].e_paddr));
      chk($sformatf("A row%0d portval", i),  48'(a_pval),  48'(vt[i].e_pval));
      chk($sformatf("A row%0d rdata", i),    48'(a_rdata), 48'(vt[i].e_rdata));
      $display("A row %0d: req=%b ack=%b busy=%b set=%b get=%b paddr=%h rdata=%h",
               i, vt[i].req, a_ack, a_busy, a_set, a_get, a_paddr, a_rdata);
    end
    a_req = '0;

    // ---- Instance B: 3-cycle read by requester 1 ----
    tick();
    b_rst = 1'b0;
    tick();
    b_req = 2'b10; b_wr = 2'b00; b_addr = {16'h0003, 16'h0000}; b_pout = 16'h1234;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("B read acc%0d portget", i), 48'(b_get), 48'd1);
      chk($sformatf("B read acc%0d portset", i), 48'(b_set), 48'd0);
      chk($sformatf("B read acc%0d ack", i), 48'(b_ack), 48'd0);
      chk($sformatf("B read acc%0d portaddr", i), 48'(b_paddr), 48'h0003);
      tick();
    end
    chk("B read done ack", 48'(b_ack), 48'b10);
    chk("B read done rdata", 48'(b_rdata), 48'h1234);
    chk("B read done portget", 48'(b_get), 48'd0);
    $display("B read: ack=%b rdata=%h", b_ack, b_rdata);
    b_req = 2'b00;
    tick();
    chk("B read idle ack", 48'(b_ack), 48'd0);

    // ---- Instance B: write by requester 0 moves the pointer to 1 ----
    b_req = 2'b01; b_wr = 2'b01; b_addr = {16'h0000, 16'h0044}; b_wdata = {16'h0000, 16'h00AA};
    tick();
    chk("B wr acc0 portset", 48'(b_set), 48'd1);
    chk("B wr acc0 portval", 48'(b_pval), 48'h00AA);
    tick();
    chk("B wr acc1 portset", 48'(b_set), 48'd0);
    tick();
    tick();
    chk("B wr done ack", 48'(b_ack), 48'b01);
    $display("B write: ack=%b", b_ack);
    b_req = 2'b00;
    tick();

    // ---- Instance B: reset aborts a requester-1 read mid-access ----
    b_req = 2'b10; b_wr = 2'b00; b_addr = {16'h0055, 16'h0066};
    tick();
    chk("B abort grant portaddr", 48'(b_paddr), 48'h0055);
    tick();
    b_rst = 1'b1; b_req = 2'b00;
    tick();
    chk("B abort busy", 48'(b_busy), 48'd0);
    chk("B abort portget", 48'(b_get), 48'd0);
    chk("B abort ack", 48'(b_ack), 48'd0);
    chk("B abort portaddr", 48'(b_paddr), 48'd0);
    b_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("B post-abort%0d ack", i), 48'(b_ack), 48'd0);
      chk($sformatf("B post-abort%0d strobes", i), 48'({b_get, b_set}), 48'd0);
    end
    b_req = 2'b11; b_addr = {16'h0077, 16'h0066};
    tick();
    chk("B post-abort grant portaddr", 48'(b_paddr), 48'h0066);
    tick(); tick(); tick();
    chk("B post-abort ack", 48'(b_ack), 48'b01);
    $display("B abort: post-reset winner ack=%b", b_ack);
    b_req = 2'b00;

    // ---- Instance C: wrap from pointer 2 ----
    c_rst = 1'b0;
    tick();
    c_req = 3'b010;
    tick();
    chk("C t0 portaddr", 48'(c_paddr), 48'h0C01);
    tick();
    chk("C t0 ack", 48'(c_ack), 48'b010);
    c_req = 3'b011;
    tick();
    chk("C t0 idle busy", 48'(c_busy), 48'd0);
    tick();
    chk("C t1 portaddr", 48'(c_paddr), 48'h0C00);
    tick();
    chk("C t1 ack", 48'(c_ack), 48'b001);
    $display("C wrap: ack=%b", c_ack);
    tick();
    tick();
    chk("C t2 portaddr", 48'(c_paddr), 48'h0C01);
    tick();
    chk("C t2 ack", 48'(c_ack), 48'b010);
    c_req = 3'b111;
    tick();
    tick();
    chk("C t3 portaddr", 48'(c_paddr), 48'h0C02);
    tick();
    chk("C t3 ack", 48'(c_ack), 48'b100);
    $display("C pointer-2 grant: ack=%b", c_ack);
    c_req = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
